bnn_sequencer: RTL and testbench

//  Host-side controller for the tiny_bnn core. Serialises a weight/threshold bitstream into
//  the core's parameter shift chain, then runs inferences: splits each 8-bit input into two

---
 rtl/bnn_sequencer.sv | 160 ++++++++++++++++
 tb/tb_bnn_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_sequencer.sv
// Host-side controller for the tiny_bnn core: streams the parameter chain in setup mode,
// then runs one nibble-split inference at a time and returns the core output via valid/ready.
module bnn_sequencer #(
   parameter int PARAM_BITS     = 232,
   parameter int RESULT_LATENCY = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cfg_start,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [7:0] cfg_data,
   output logic       cfg_done,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   input  logic [7:0] bnn_out,
   output logic       bnn_setup,
   output logic       bnn_param,
   output logic       bnn_bank_hi,
   output logic [3:0] bnn_x
);

   localparam int CW = $clog2(PARAM_BITS + 1);
   localparam int WW = $clog2(RESULT_LATENCY + 1);

   typedef enum logic [2:0] {UNCFG, CFG_LOAD, CFG_SHIFT, IDLE, LO, HI, WAIT, OUT} state_t;

   state_t        state_q;
   logic [CW-1:0] bitCnt_q;
   logic [2:0]    byteIdx_q;
   logic [6:0]    shiftReg_q;
   logic [3:0]    hiNibble_q;
   logic [WW-1:0] waitCnt_q;
   logic          cfgReady_q;
   logic          cfgDone_q;
   logic          inReady_q;
   logic          outValid_q;
   logic [7:0]    outData_q;
   logic          setup_q;
   logic          param_q;
   logic          bankHi_q;
   logic [3:0]    x_q;

   // cfg_start restarts configuration from any state; the core is pushed back into setup
   // with cleared inputs and any inference in flight is silently dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= UNCFG;
         bitCnt_q   <= '0;
         byteIdx_q  <= '0;
         shiftReg_q <= '0;
         hiNibble_q <= '0;
         waitCnt_q  <= '0;
         cfgReady_q <= 1'b0;
         cfgDone_q  <= 1'b0;
         inReady_q  <= 1'b0;
         outValid_q <= 1'b0;
         outData_q  <= '0;
         setup_q    <= 1'b1;
         param_q    <= 1'b0;
         bankHi_q   <= 1'b0;
         x_q        <= '0;
      end else if (cfg_start) begin
         state_q    <= CFG_LOAD;
         bitCnt_q   <= '0;
         cfgReady_q <= 1'b1;
         cfgDone_q  <= 1'b0;
         inReady_q  <= 1'b0;
         outValid_q <= 1'b0;
         setup_q    <= 1'b1;
         param_q    <= 1'b0;
         bankHi_q   <= 1'b0;
         x_q        <= '0;
      end else begin
         case (state_q)
            CFG_LOAD: begin
               if (cfg_valid && cfgReady_q) begin
                  param_q    <= cfg_data[0];
                  shiftReg_q <= cfg_data[7:1];
                  byteIdx_q  <= '0;
                  cfgReady_q <= 1'b0;
                  state_q    <= CFG_SHIFT;
               end
            end
            // Each cycle here presents one chain bit; the tail of the last byte is dropped
            // as soon as the chain is full.
            CFG_SHIFT: begin
               bitCnt_q <= bitCnt_q + 1'b1;
               if (bitCnt_q == CW'(PARAM_BITS - 1)) begin
                  setup_q   <= 1'b0;
                  param_q   <= 1'b0;
                  cfgDone_q <= 1'b1;
                  inReady_q <= 1'b1;
                  state_q   <= IDLE;
               end else if (byteIdx_q == 3'd7) begin
                  param_q    <= 1'b0;
                  cfgReady_q <= 1'b1;
                  state_q    <= CFG_LOAD;
               end else begin
                  param_q    <= shiftReg_q[0];
                  shiftReg_q <= {1'b0, shiftReg_q[6:1]};
                  byteIdx_q  <= byteIdx_q + 3'd1;
               end
            end
            IDLE: begin
               if (in_valid && inReady_q) begin
                  x_q        <= in_data[3:0];
                  bankHi_q   <= 1'b0;
                  hiNibble_q <= in_data[7:4];
                  inReady_q  <= 1'b0;
                  state_q    <= LO;
               end
            end
            LO: begin
               x_q      <= hiNibble_q;
               bankHi_q <= 1'b1;
               state_q  <= HI;
            end
            HI: begin
               waitCnt_q <= WW'(1);
               state_q   <= WAIT;
            end
            // The core rewrites the selected bank every cycle, so x/bank_hi stay on the
            // high nibble until the result has been captured.
            WAIT: begin
               if (waitCnt_q == WW'(RESULT_LATENCY)) begin
                  outData_q  <= bnn_out;
                  outValid_q <= 1'b1;
                  state_q    <= OUT;
               end else begin
                  waitCnt_q <= waitCnt_q + 1'b1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  outValid_q <= 1'b0;
                  inReady_q  <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   assign cfg_ready   = cfgReady_q;
   assign cfg_done    = cfgDone_q;
   assign in_ready    = inReady_q;
   assign out_valid   = outValid_q;
   assign out_data    = outData_q;
   assign bnn_setup   = setup_q;
   assign bnn_param   = param_q;
   assign bnn_bank_hi = bankHi_q;
   assign bnn_x       = x_q;

endmodule

// File: tb/tb_bnn_sequencer.sv
// Self-checking bench for bnn_sequencer: a tiny core model answers on bnn_out, expected
// results come from the core's input/output rule applied directly to each host byte.
module tb_bnn_sequencer;

   localparam int PARAM_BITS     = 12;
   localparam int RESULT_LATENCY = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_start;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [7:0] cfg_data;
   logic       cfg_done;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [7:0] bnn_out;
   logic       bnn_setup;
   logic       bnn_param;
   logic       bnn_bank_hi;
   logic [3:0] bnn_x;

   int testsRun    = 0;
   int testsFailed = 0;
   int acceptCount = 0;
   int expAccepts  = 0;

   logic [3:0] coreLo = 4'h0;
   logic [3:0] coreHi = 4'h0;

   typedef struct {
      logic [7:0] inData;
      int         hold;
      logic [7:0] expOut;
   } vector_t;

   vector_t vectors[6];

   always #5 clk = ~clk;

   bnn_sequencer #(
      .PARAM_BITS    (PARAM_BITS),
      .RESULT_LATENCY(RESULT_LATENCY)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_start  (cfg_start),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_data   (cfg_data),
      .cfg_done   (cfg_done),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .bnn_out    (bnn_out),
      .bnn_setup  (bnn_setup),
      .bnn_param  (bnn_param),
      .bnn_bank_hi(bnn_bank_hi),
      .bnn_x      (bnn_x)
   );

   // Core response to an assembled 8-bit input vector {hi, lo}.
   function automatic logic [7:0] coreF(input logic [7:0] v);
      return v * 8'd29 + 8'd7;
   endfunction

   // Core model: while out of setup it writes the selected bank every clock.
   always @(posedge clk) begin
      if (!bnn_setup) begin
         if (bnn_bank_hi) coreHi <= bnn_x;
         else             coreLo <= bnn_x;
      end
   end

   assign bnn_out = coreF({coreHi, coreLo});

   always @(posedge clk) begin
      if (in_valid && in_ready) acceptCount++;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Runs a full configuration and checks the bit stream presented under setup.
   task automatic configure(input logic [7:0] b0, input logic [7:0] b1);
      logic [7:0]  bytes[2];
      logic [31:0] seen;
      logic [31:0] expBits;
      int          nSeen;
      int          idx;
      bit          done;
      bytes[0] = b0;
      bytes[1] = b1;
      seen     = '0;
      expBits  = '0;
      nSeen    = 0;
      idx      = 0;
      done     = 1'b0;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      checkOutput("cfg_ready after cfg_start", 32'(cfg_ready), 32'd1);
      for (int c = 0; c < 200 && !done; c++) begin
         if (cfg_done) begin
            done = 1'b1;
         end else begin
            if (bnn_setup && !cfg_ready) begin
               if (nSeen < 32) seen[nSeen] = bnn_param;
               nSeen++;
            end
            if (cfg_ready && idx < 2) begin
               cfg_valid = 1'b1;
               cfg_data  = bytes[idx];
               idx++;
            end else begin
               cfg_valid = 1'b0;
               cfg_data  = 8'($urandom);
            end
            @(negedge clk);
         end
      end
      cfg_valid = 1'b0;
      for (int i = 0; i < PARAM_BITS; i++)
         expBits[i] = (i < 8) ? b0[i] : b1[i-8];
      checkOutput("cfg completes", 32'(done), 32'd1);
      checkOutput("param bit count", 32'(nSeen), 32'(PARAM_BITS));
      checkOutput("param bit stream", seen, expBits);
      checkOutput("setup low after cfg", 32'(bnn_setup), 32'd0);
      checkOutput("param low after cfg", 32'(bnn_param), 32'd0);
      checkOutput("in_ready after cfg", 32'(in_ready), 32'd1);
      checkOutput("cfg_ready after cfg", 32'(cfg_ready), 32'd0);
   endtask

   // One inference: nibble sequencing, exact result latency, stall hold, and release.
   task automatic applyStimulus(input logic [7:0] data, input int holdCycles,
                                input logic [7:0] expOut);
      checkOutput("in_ready before accept", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = data;
      expAccepts++;
      @(negedge clk);
      checkOutput("lo nibble x", 32'(bnn_x), 32'(data[3:0]));
      checkOutput("lo nibble bank", 32'(bnn_bank_hi), 32'd0);
      checkOutput("in_ready busy", 32'(in_ready), 32'd0);
      in_data = ~data;
      @(negedge clk);
      checkOutput("hi nibble x", 32'(bnn_x), 32'(data[7:4]));
      checkOutput("hi nibble bank", 32'(bnn_bank_hi), 32'd1);
      checkOutput("out_valid early", 32'(out_valid), 32'd0);
      @(negedge clk);
      checkOutput("wait x held", 32'({bnn_bank_hi, bnn_x}), 32'({1'b1, data[7:4]}));
      checkOutput("out_valid early wait", 32'(out_valid), 32'd0);
      @(negedge clk);
      checkOutput("out_valid at latency", 32'(out_valid), 32'd1);
      checkOutput("out_data", 32'(out_data), 32'(expOut));
      for (int h = 0; h < holdCycles; h++) begin
         @(negedge clk);
         checkOutput("stall out hold", 32'({in_ready, out_valid, out_data}),
                     32'({1'b0, 1'b1, expOut}));
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("out_valid release", 32'(out_valid), 32'd0);
      checkOutput("in_ready after release", 32'(in_ready), 32'd1);
      checkOutput("accept count", 32'(acceptCount), 32'(expAccepts));
   endtask

   initial begin
      int  gap;
      bit  sawValid;
      logic [7:0] d;

      vectors[0] = '{8'h00, 0, coreF(8'h00)};
      vectors[1] = '{8'hFF, 1, coreF(8'hFF)};
      vectors[2] = '{8'hA5, 0, coreF(8'hA5)};
      vectors[3] = '{8'h5A, 2, coreF(8'h5A)};
      vectors[4] = '{8'h81, 0, coreF(8'h81)};
      vectors[5] = '{8'h7E, 3, coreF(8'h7E)};

      reset     = 1'b1;
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = 8'h00;
      in_valid  = 1'b1;
      in_data   = 8'h3C;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      checkOutput("reset setup", 32'(bnn_setup), 32'd1);
      checkOutput("reset cfg_ready", 32'(cfg_ready), 32'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("idle setup", 32'(bnn_setup), 32'd1);
      checkOutput("idle cfg_ready", 32'(cfg_ready), 32'd0);
      checkOutput("idle in_ready", 32'(in_ready), 32'd0);
      checkOutput("idle out_valid", 32'(out_valid), 32'd0);
      checkOutput("idle cfg_done", 32'(cfg_done), 32'd0);
      checkOutput("idle core pins", 32'({bnn_param, bnn_bank_hi, bnn_x, out_data}), 32'd0);

      configure(8'hA5, 8'h0F);
      checkOutput("no accept before cfg", 32'(acceptCount), 32'd0);
      checkOutput("cfg_done set", 32'(cfg_done), 32'd1);

      applyStimulus(8'h3C, 5, coreF(8'h3C));

      for (int v = 0; v < 6; v++)
         applyStimulus(vectors[v].inData, vectors[v].hold, vectors[v].expOut);

      for (int r = 0; r < 16; r++) begin
         gap = int'($urandom_range(0, 2));
         repeat (gap) @(negedge clk);
         d = 8'($urandom);
         applyStimulus(d, int'($urandom_range(0, 3)), coreF(d));
      end

      // Abort an inference while it waits on the core.
      in_valid = 1'b1;
      in_data  = 8'h96;
      expAccepts++;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      checkOutput("abort setup", 32'(bnn_setup), 32'd1);
      checkOutput("abort cfg_ready", 32'(cfg_ready), 32'd1);
      checkOutput("abort cfg_done", 32'(cfg_done), 32'd0);
      checkOutput("abort in_ready", 32'(in_ready), 32'd0);
      sawValid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (out_valid) sawValid = 1'b1;
         @(negedge clk);
      end
      checkOutput("abort no output", 32'(sawValid), 32'd0);

      configure(8'h3B, 8'hC6);
      applyStimulus(8'h96, 1, coreF(8'h96));
      applyStimulus(8'h4D, 0, coreF(8'h4D));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
